// File: rtl/axi_gpio_irq_if.sv
// axi_gpio_irq_if: AXI4-Lite bus bundle for the GPIO peripheral.
// Write responses are always OKAY, so the bundle carries no resp signals.
interface axi_gpio_irq_if;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
  );
endinterface

// File: rtl/axi_gpio_irq.sv
// axi_gpio_irq: AXI4-Lite GPIO with direction, atomic set/clear, synchronised inputs and edge IRQs.
// Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter after the synchroniser.
module axi_gpio_irq #(
  parameter int unsigned GPIO_WIDTH      = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_gpio_irq_if.slave         s_axi,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  typedef enum logic [2:0] {
    REG_DATA_IN    = 3'd0,
    REG_DATA_OUT   = 3'd1,
    REG_DIR        = 3'd2,
    REG_RISE_EN    = 3'd3,
    REG_FALL_EN    = 3'd4,
    REG_IRQ_STATUS = 3'd5,
    REG_OUT_SET    = 3'd6,
    REG_OUT_CLR    = 3'd7
  } reg_off_e;

  logic [GPIO_WIDTH-1:0] data_out, dir, rise_en, fall_en, irq_status;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] sync_in, filt_in, prev_in, rise, fall;
  logic [GPIO_WIDTH-1:0] wmask, wbits, w1c_mask;
  logic [31:0]           strb_mask, rd_mux, rdata;
  logic                  bvalid, rvalid, wr_en, rd_en;
  reg_off_e              wr_off, rd_off;
  logic                  unused_bits;

  assign s_axi.s_awready = !bvalid;
  assign s_axi.s_wready  = !bvalid;
  assign s_axi.s_bvalid  = bvalid;
  assign s_axi.s_arready = !rvalid;
  assign s_axi.s_rvalid  = rvalid;
  assign s_axi.s_rdata   = rdata;

  assign wr_en  = s_axi.s_awvalid && s_axi.s_wvalid && !bvalid;
  assign rd_en  = s_axi.s_arvalid && !rvalid;
  assign wr_off = reg_off_e'(s_axi.s_awaddr[4:2]);
  assign rd_off = reg_off_e'(s_axi.s_araddr[4:2]);

  always_comb begin
    strb_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      strb_mask[8*i +: 8] = {8{s_axi.s_wstrb[i]}};
    end
  end

  assign wmask    = strb_mask[GPIO_WIDTH-1:0];
  assign wbits    = s_axi.s_wdata[GPIO_WIDTH-1:0] & wmask;
  assign w1c_mask = (wr_en && wr_off == REG_IRQ_STATUS) ? wbits : '0;

  assign unused_bits = ^{s_axi.s_awaddr[31:5], s_axi.s_awaddr[1:0],
                         s_axi.s_araddr[31:5], s_axi.s_araddr[1:0],
                         s_axi.s_wdata, strb_mask};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      bvalid   <= 1'b0;
    end else begin
      if (bvalid && s_axi.s_bready) begin
        bvalid <= 1'b0;
      end else if (wr_en) begin
        bvalid <= 1'b1;
      end
      if (wr_en) begin
        case (wr_off)
          REG_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
          REG_DIR:      dir      <= (dir & ~wmask) | wbits;
          REG_RISE_EN:  rise_en  <= (rise_en & ~wmask) | wbits;
          REG_FALL_EN:  fall_en  <= (fall_en & ~wmask) | wbits;
          REG_OUT_SET:  data_out <= data_out | wbits;
          REG_OUT_CLR:  data_out <= data_out & ~wbits;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      REG_DATA_IN:    rd_mux = 32'(filt_in);
      REG_DATA_OUT:   rd_mux = 32'(data_out);
      REG_DIR:        rd_mux = 32'(dir);
      REG_RISE_EN:    rd_mux = 32'(rise_en);
      REG_FALL_EN:    rd_mux = 32'(fall_en);
      REG_IRQ_STATUS: rd_mux = 32'(irq_status);
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_en) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (rvalid && s_axi.s_rready) begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_in <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_in <= filt_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0]      db_cnt [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] filt_q;

  // Counter tracks consecutive cycles of disagreement; it never passes DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        if (sync_in[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync_in[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign filt_in = filt_q;
`else
  logic unused_cfg;
  assign unused_cfg = 1'(DEBOUNCE_CYCLES % 2);
  assign filt_in    = sync_in;
`endif

  assign rise = filt_in & ~prev_in;
  assign fall = ~filt_in & prev_in;

  // New edges are OR-ed in after the W1C clear, so a same-cycle edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~w1c_mask) | (rise & rise_en) | (fall & fall_en);
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;
  assign irq      = |irq_status;

endmodule

// File: tb/tb_axi_gpio_irq.sv
// tb_axi_gpio_irq: scoreboard bench for axi_gpio_irq with a register-level reference model.
// Directed scenarios first, then randomized register traffic and pin activity.
module tb_axi_gpio_irq;
  localparam int unsigned W    = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned LAT = SYNC + 1 + DEB;
`else
  localparam int unsigned LAT = SYNC + 1;
`endif
  localparam int unsigned SETTLE = LAT + 4;
  localparam logic [31:0] WMASK = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_in, gpio_out, gpio_oe;
  logic         irq;

  axi_gpio_irq_if bus();

  axi_gpio_irq #(
    .GPIO_WIDTH(W),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi(bus),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rd [$];
  int          exp_b  [$];
  logic [31:0] mon_exp;

  // Reference model: architectural register values
  logic [31:0] m_in, m_out, m_dir, m_rise, m_fall, m_stat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected DUT handshake", name);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] off);
    logic [31:0] r;
    r = $urandom;
    return {r[31:5], off, r[1:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return m_in;
      3'd1:    return m_out;
      3'd2:    return m_dir;
      3'd3:    return m_rise;
      3'd4:    return m_fall;
      3'd5:    return m_stat;
      default: return '0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m, b;
    m = byte_mask(strb) & WMASK;
    b = data & m;
    case (off)
      3'd1: m_out  = (m_out & ~m) | b;
      3'd2: m_dir  = (m_dir & ~m) | b;
      3'd3: m_rise = (m_rise & ~m) | b;
      3'd4: m_fall = (m_fall & ~m) | b;
      3'd5: m_stat = m_stat & ~b;
      3'd6: m_out  = m_out | b;
      3'd7: m_out  = m_out & ~b;
      default: ;
    endcase
  endtask

  task automatic model_edges(input logic [31:0] v);
    logic [31:0] nv;
    nv = v & WMASK;
    m_stat = m_stat | ((nv & ~m_in) & m_rise) | ((~nv & m_in) & m_fall);
    m_in = nv;
  endtask

  task automatic model_reset();
    m_in = '0; m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0;
  endtask

  task automatic wr_issue(input logic [2:0] off, input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.s_awaddr  = rand_addr(off);
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    @(negedge clk);
    while (!(bus.s_awready && bus.s_wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_timeout("wr_accept");
    else begin
      model_write(off, data, strb);
      exp_b.push_back(1);
    end
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
  endtask

  task automatic wait_b_done();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.s_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_timeout("b_done");
  endtask

  task automatic rd_issue(input logic [2:0] off);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.s_araddr  = rand_addr(off);
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_timeout("rd_accept");
    else exp_rd.push_back(model_read(off));
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
  endtask

  task automatic wait_r_done();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.s_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_timeout("r_done");
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    wr_issue(off, data, 4'hF);
    wait_b_done();
  endtask

  task automatic rd(input logic [2:0] off);
    rd_issue(off);
    wait_r_done();
  endtask

  task automatic pin_set(input logic [W-1:0] v);
    @(posedge clk); #1;
    gpio_in = v;
    repeat (SETTLE) @(posedge clk);
    model_edges(32'(v));
  endtask

  task automatic check_pins(input string tag);
    @(negedge clk);
    check({tag, "_gpio_out"}, 32'(gpio_out), m_out);
    check({tag, "_gpio_oe"}, 32'(gpio_oe), m_dir);
    check({tag, "_irq"}, 32'(irq), 32'(|m_stat));
  endtask

  // Response monitor: pops expectations when the DUT completes a handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.s_rvalid && bus.s_rready) begin
        if (exp_rd.size() == 0) begin
          fail_timeout("rd_unexpected");
        end else begin
          mon_exp = exp_rd.pop_front();
          check("rdata", bus.s_rdata, mon_exp);
        end
      end
      if (bus.s_bvalid && bus.s_bready) begin
        n_tests++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL bresp: got unexpected response expected none");
        end else begin
          void'(exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
    int          n;

    rst_n = 1'b0;
    gpio_in = '0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b1; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_bvalid", 32'(bus.s_bvalid), 32'h0);
    check("rst_rvalid", 32'(bus.s_rvalid), 32'h0);
    check("rst_rdata", bus.s_rdata, 32'h0);
    rst_n = 1'b1;

    // Direction, data, atomic set/clear
    wr(3'd2, 32'h00FF);
    wr(3'd1, 32'h1234);
    wr(3'd6, 32'h0001);
    wr(3'd7, 32'h0030);
    @(negedge clk);
    check("gpio_out_setclr", 32'(gpio_out), 32'h1205);
    check("gpio_oe_dir", 32'(gpio_oe), 32'h00FF);
    rd(3'd1);
    rd(3'd2);

    // Rising edge interrupt latency, W1C, disabled falling edge
    wr(3'd3, 32'h0004);
    @(posedge clk); #1;
    gpio_in[2] = 1'b1;
    n = 0;
    while (!irq && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("irq_latency", 32'(n), 32'(LAT));
    repeat (SETTLE) @(posedge clk);
    model_edges(32'(gpio_in));
    rd(3'd5);
    wr(3'd5, 32'h0004);
    check_pins("w1c");
    pin_set(gpio_in & ~W'(4));
    check_pins("fall_disabled");
    rd(3'd5);

    // Byte strobes and write address waiting for its data
    wr(3'd1, 32'h0000);
    @(posedge clk); #1;
    bus.s_awaddr  = rand_addr(3'd1);
    bus.s_wdata   = 32'hAAAA;
    bus.s_wstrb   = 4'b0010;
    bus.s_awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bvalid_aw_only", 32'(bus.s_bvalid), 32'h0);
    end
    @(posedge clk); #1;
    bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("awready_with_w", 32'(bus.s_awready), 32'h1);
    model_write(3'd1, 32'hAAAA, 4'b0010);
    exp_b.push_back(1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    wait_b_done();
    @(negedge clk);
    check("gpio_out_strb", 32'(gpio_out), 32'hAA00);

    // Backpressure on both response channels
    bus.s_bready = 1'b0;
    wr_issue(3'd2, 32'h00F0, 4'hF);
    repeat (5) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bus.s_bvalid), 32'h1);
      check("awready_hold", 32'(bus.s_awready), 32'h0);
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b1;
    wait_b_done();
    bus.s_rready = 1'b0;
    rd_issue(3'd2);
    repeat (5) begin
      @(negedge clk);
      check("rvalid_hold", 32'(bus.s_rvalid), 32'h1);
      check("arready_hold", 32'(bus.s_arready), 32'h0);
      check("rdata_hold", bus.s_rdata, m_dir);
    end
    @(posedge clk); #1;
    bus.s_rready = 1'b1;
    wait_r_done();

    // W1C accepted on the very edge that latches a new rise
    @(posedge clk); #1;
    gpio_in[2] = 1'b1;
    repeat (LAT - 2) @(posedge clk);
    wr_issue(3'd5, 32'h0004, 4'hF);
    model_edges(32'(gpio_in));
    wait_b_done();
    rd(3'd5);
    check_pins("w1c_vs_edge");

    // Asynchronous reset while a write response is pending
    bus.s_bready = 1'b0;
    wr_issue(3'd1, 32'hFFFF, 4'hF);
    @(negedge clk);
    check("bvalid_before_rst", 32'(bus.s_bvalid), 32'h1);
    #2;
    rst_n = 1'b0;
    gpio_in = '0;
    #1;
    check("rst_mid_bvalid", 32'(bus.s_bvalid), 32'h0);
    check("rst_mid_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_mid_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    exp_b.delete();
    exp_rd.delete();
    model_reset();
    bus.s_bready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized register traffic and pin activity
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          off  = 3'($urandom_range(0, 7));
          data = $urandom;
          strb = 4'($urandom_range(0, 15));
          wr_issue(off, data, strb);
          wait_b_done();
          check_pins("rand_wr");
        end
        2: begin
          off = 3'($urandom_range(0, 7));
          rd(off);
        end
        default: begin
          data = $urandom;
          pin_set(data[W-1:0]);
          check_pins("rand_pin");
        end
      endcase
    end

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short pulse ignored, long pulse accepted
    wr(3'd5, WMASK);
    pin_set('0);
    wr(3'd5, WMASK);
    wr(3'd3, 32'h0001);
    wr(3'd4, 32'h0000);
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    gpio_in[0] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    rd(3'd0);
    check_pins("db_short");
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    gpio_in[0] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    model_edges(32'h1);
    model_edges(32'h0);
    rd(3'd5);
    check_pins("db_long");
`endif

    repeat (4) @(posedge clk);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    check("b_queue_drained", 32'(exp_b.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
